// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx: takes filtered 16-bit mono samples from the FIR stage, buffers
// them in a small first-word-fall-through FIFO and sends each one on both
// channels of a Philips I2S master link to the audio DAC. BCLK and LRCLK are
// divided down from clk, so everything runs in the FIR clock domain.
//
// Ports:
//   clk         system clock, shared with the FIR stage
//   reset       asynchronous, active-high reset
//   sample_in   16-bit signed sample from the FIR source
//   valid_in    sample_in qualifier, one clk per sample, no backpressure
//   i2s_bclk    bit clock, 50% duty, BCLK_DIV clk per period
//   i2s_lrclk   word select, 0 = left, 1 = right
//   i2s_sdata   serial data, MSB first, changes with the BCLK falling edge
//   fifo_level  current FIFO occupancy
//   overflow    sticky flag, set when a valid_in sample is dropped
//   underflow   one-clk pulse when a frame load finds the FIFO empty
//
// Build option: define FIR_I2S_HOLD_LAST_EN to resend the last popped sample
// on underflow instead of silence.

module fir_i2s_tx #(
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   sample_in,
  input  logic                          valid_in,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int DW   = $clog2(BCLK_DIV);
  localparam int HALF = BCLK_DIV / 2;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]    slot_q, slot_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic [31:0]   shift_q, shift_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];

  logic          fe;
  logic          load;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic [31:0]   uf_word;

`ifdef FIR_I2S_HOLD_LAST_EN
  logic [15:0] last_sample_q, last_sample_d;

  always_comb begin
    last_sample_d = pop ? head : last_sample_q;
    uf_word       = {last_sample_q, last_sample_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_sample_q <= '0;
    else       last_sample_q <= last_sample_d;
  end
`else
  assign uf_word = 32'h0;
`endif

  always_comb begin
    // fe marks the clk on which BCLK falls; all slot/data updates land with it
    fe        = (div_cnt_q == DW'(BCLK_DIV - 1));
    div_cnt_d = fe ? '0 : div_cnt_q + 1'b1;
    // Derived from the next count so BCLK falls on the same edge sdata moves
    bclk_d    = (div_cnt_d >= DW'(HALF));
    slot_d    = fe ? slot_q + 5'd1 : slot_q;
    lrclk_d   = slot_d[4];

    load  = fe && (slot_q == 5'd0);
    empty = (level_q == '0);
    full  = (level_q == LW'(FIFO_DEPTH));
    head  = mem_q[rd_ptr_q];
    pop   = load && !empty;
    // A full FIFO still accepts a sample when the same clk pops one
    push  = valid_in && (!full || pop);

    shift_d = shift_q;
    if (load)    shift_d = empty ? uf_word : {head, head};
    else if (fe) shift_d = {shift_q[30:0], 1'b0};

    underflow_d = load && empty;
    overflow_d  = overflow_q | (valid_in & ~push);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = sample_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      slot_q      <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mem_q       <= '{default: '0};
    end else begin
      div_cnt_q   <= div_cnt_d;
      slot_q      <= slot_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      shift_q     <= shift_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mem_q       <= mem_d;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = shift_q[31];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_fir_i2s_tx.sv
// Directed bench for fir_i2s_tx with BCLK_DIV=4 (128 clk per frame) and
// FIFO_DEPTH=16. cyc counts clk edges since reset release: after edge c the
// divider is at c%4, the slot is (c/4)%32, and frame f loads at edge 4+128f.

module tb_fir_i2s_tx;

  localparam int BCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_in = '0;
  logic        valid_in = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  fir_i2s_tx #(.BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_in  (sample_in),
    .valid_in   (valid_in),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    if (cyc > target) chk("run_to_overshoot", cyc, target);
    while (cyc < target) tick();
  endtask

  function automatic logic [15:0] uf_word(input logic [15:0] last);
`ifdef FIR_I2S_HOLD_LAST_EN
    return last;
`else
    return 16'h0000;
`endif
  endfunction

  // Called at a negedge; asserts reset for one clk and releases on the next negedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_bclk",  i2s_bclk,   0);
    chk("rst_lrclk", i2s_lrclk,  0);
    chk("rst_sdata", i2s_sdata,  0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf",   overflow,   0);
    chk("rst_udf",   underflow,  0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  // Collects slots 1..31 of frame f plus slot 0 of the next frame.
  task automatic frame_check(input int f, input logic [15:0] w, input logic exp_uf, input string tag);
    logic [31:0] sd;
    logic [31:0] lr;
    sd = '0;
    lr = '0;
    run_to(4 + 128*f);
    chk({tag, "_udf"}, underflow, exp_uf);
    for (int s = 1; s <= 32; s++) begin
      run_to(4 + 128*f + 4*(s-1) + 1);
      if (s == 1) chk({tag, "_udf_end"}, underflow, 0);
      sd = {sd[30:0], i2s_sdata};
      lr = {lr[30:0], i2s_lrclk};
    end
    chk({tag, "_sdata"}, sd, {w, w});
    chk({tag, "_lrclk"}, lr, 32'h0001_FFFE);
  endtask

  initial begin
    @(negedge clk);

    // Idle: clocks only, silence, one underflow per frame
    do_reset();
    for (int c = 1; c <= 256; c++) begin
      tick();
      chk("idle_bclk",  i2s_bclk,   ((c % 4) >= 2) ? 1 : 0);
      chk("idle_lrclk", i2s_lrclk,  (((c / 4) % 32) >= 16) ? 1 : 0);
      chk("idle_sdata", i2s_sdata,  0);
      chk("idle_udf",   underflow,  ((c % 128) == 4) ? 1 : 0);
      chk("idle_level", fifo_level, 0);
    end

    // Single sample pushed before the first load
    do_reset();
    sample_in = 16'hA5C3;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    chk("a5_level_push", fifo_level, 1);
    run_to(3);
    chk("a5_level_hold", fifo_level, 1);
    run_to(4);
    chk("a5_level_load", fifo_level, 0);
    frame_check(0, 16'hA5C3, 1'b0, "a5_f0");

    // Extremes in two back-to-back frames, then underflow
    do_reset();
    sample_in = 16'h8000;
    valid_in  = 1'b1;
    tick();
    sample_in = 16'h7FFF;
    tick();
    valid_in  = 1'b0;
    chk("ext_level", fifo_level, 2);
    frame_check(0, 16'h8000, 1'b0, "ext_f0");
    frame_check(1, 16'h7FFF, 1'b0, "ext_f1");
    frame_check(2, uf_word(16'h7FFF), 1'b1, "ext_f2");

    // Full FIFO with push coincident with a load
    do_reset();
    run_to(4);
    for (int i = 1; i <= 16; i++) begin
      sample_in = 16'h2000 + 16'(i);
      valid_in  = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    chk("coin_level_full", fifo_level, 16);
    chk("coin_ovf_full",   overflow,   0);
    run_to(131);
    sample_in = 16'h2011;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    chk("coin_level", fifo_level, 16);
    chk("coin_ovf",   overflow,   0);
    frame_check(1, 16'h2001, 1'b0, "coin_f1");
    frame_check(17, 16'h2011, 1'b0, "coin_f17");
    chk("coin_ovf_end", overflow, 0);

    // 17 pushes with no load in between: last one dropped
    do_reset();
    run_to(4);
    for (int i = 1; i <= 17; i++) begin
      sample_in = 16'h1000 + 16'(i);
      valid_in  = 1'b1;
      tick();
      if (i == 16) begin
        chk("ovf_level_16", fifo_level, 16);
        chk("ovf_clear_16", overflow,   0);
      end
    end
    valid_in = 1'b0;
    chk("ovf_level_17", fifo_level, 16);
    chk("ovf_set",      overflow,   1);
    for (int f = 1; f <= 16; f++) begin
      frame_check(f, 16'h1000 + 16'(f), 1'b0, "ovf_frame");
    end
    frame_check(17, uf_word(16'h1010), 1'b1, "ovf_f17");
    chk("ovf_sticky", overflow, 1);

    // Reset in the middle of slot 20 with data queued and overflow set
    run_to(2309);
    sample_in = 16'h3333;
    valid_in  = 1'b1;
    tick();
    tick();
    valid_in  = 1'b0;
    chk("mid_level_pre", fifo_level, 2);
    run_to(2386);
    chk("mid_bclk_pre",  i2s_bclk,   1);
    chk("mid_lrclk_pre", i2s_lrclk,  1);
    chk("mid_ovf_pre",   overflow,   1);
    chk("mid_level_pre2", fifo_level, 2);
    do_reset();
    frame_check(0, 16'h0000, 1'b1, "mid_f0");
    chk("mid_level_post", fifo_level, 0);
    chk("mid_ovf_post",   overflow,   0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
